// File: rtl/breakout_pkg.sv
// breakout_pkg: block-wall constants, layout defaults and hit-engine FSM states
// Shared by the block hit engine and the VGA renderer.
package breakout_pkg;
    localparam int NUM_BLOCKS      = 25;
    localparam int BLOCKS_PER_ROW  = 5;
    localparam logic [1:0] BLOCK_DESTROYED = 2'b11;
    localparam int DEF_BALL_SIZE       = 7;
    localparam int DEF_BLOCK_SPACING_X = 40;
    localparam int DEF_BLOCK_WIDTH     = 80;
    localparam int DEF_BLOCK_HEIGHT    = 30;
    localparam int DEF_FIRST_ROW_Y     = 40;
    localparam int DEF_ROW_PITCH       = 50;
    typedef enum logic [1:0] {CLEAR, IDLE, SCAN, WRITE} state_t;
endpackage

// File: rtl/block_overlap_check.sv
// block_overlap_check: combinational ball/block box overlap and centre-in-x test
// All arithmetic is 11 bits wide so ball edge plus size never wraps.
module block_overlap_check
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE       = DEF_BALL_SIZE,
    parameter int BLOCK_SPACING_X = DEF_BLOCK_SPACING_X,
    parameter int BLOCK_WIDTH     = DEF_BLOCK_WIDTH,
    parameter int BLOCK_HEIGHT    = DEF_BLOCK_HEIGHT,
    parameter int FIRST_ROW_Y     = DEF_FIRST_ROW_Y,
    parameter int ROW_PITCH       = DEF_ROW_PITCH
) (
    input  logic [4:0] index,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       hit_box,
    output logic       centre_in_x
);
    logic [2:0]  row, col;
    logic [10:0] bx, by, x, y, cx;
    assign row = 3'(index / 5'(BLOCKS_PER_ROW));
    assign col = 3'(index % 5'(BLOCKS_PER_ROW));
    assign bx  = 11'(BLOCK_SPACING_X) + 11'(BLOCK_SPACING_X + BLOCK_WIDTH) * 11'(col);
    assign by  = 11'(FIRST_ROW_Y) + 11'(ROW_PITCH) * 11'(row);
    assign x   = {1'b0, ball_x};
    assign y   = {1'b0, ball_y};
    assign cx  = x + 11'd3;
    assign hit_box = (x <= bx + 11'(BLOCK_WIDTH)) && (x + 11'(BALL_SIZE) >= bx) &&
                     (y <= by + 11'(BLOCK_HEIGHT)) && (y + 11'(BALL_SIZE) >= by);
    assign centre_in_x = (cx >= bx) && (cx <= bx + 11'(BLOCK_WIDTH));
endmodule

// File: rtl/block_hit_engine.sv
// block_hit_engine: per-frame block wall scan, damage write-back, bounce, score and level-clear
// Define BLOCK_HITS_MULTI_EN for three-hit blocks (state 0->1->2->3); otherwise one hit destroys.
module block_hit_engine
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE       = DEF_BALL_SIZE,
    parameter int BLOCK_SPACING_X = DEF_BLOCK_SPACING_X,
    parameter int BLOCK_WIDTH     = DEF_BLOCK_WIDTH,
    parameter int BLOCK_HEIGHT    = DEF_BLOCK_HEIGHT,
    parameter int FIRST_ROW_Y     = DEF_FIRST_ROW_Y,
    parameter int ROW_PITCH       = DEF_ROW_PITCH
) (
    input  logic        CLK_50MH,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        clear_req,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic        active_write_enable,
    output logic [5:0]  active_position,
    output logic [1:0]  active_data,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic [15:0] score,
    output logic        level_clear,
    output logic        busy
);
    state_t                        state_q;
    logic [4:0]                    idx_q, dcnt_q, dcnt_d;
    logic [9:0]                    ball_x_q, ball_y_q;
    logic [NUM_BLOCKS-1:0][1:0]    blocks_q;
    logic [15:0]                   score_q, score_d;
    logic [5:0]                    pos_q;
    logic [1:0]                    data_q, blk_d;
    logic we_q, bounce_x_q, bounce_y_q, level_q, busy_q, centre_q;
    logic hit_box, centre_in_x, hit, last_idx;

    block_overlap_check #(
        .BALL_SIZE(BALL_SIZE), .BLOCK_SPACING_X(BLOCK_SPACING_X), .BLOCK_WIDTH(BLOCK_WIDTH),
        .BLOCK_HEIGHT(BLOCK_HEIGHT), .FIRST_ROW_Y(FIRST_ROW_Y), .ROW_PITCH(ROW_PITCH)
    ) u_check (
        .index(idx_q), .ball_x(ball_x_q), .ball_y(ball_y_q),
        .hit_box(hit_box), .centre_in_x(centre_in_x)
    );

    assign hit      = hit_box && (blocks_q[idx_q] != BLOCK_DESTROYED);
    assign last_idx = idx_q == 5'(NUM_BLOCKS - 1);
`ifdef BLOCK_HITS_MULTI_EN
    assign blk_d = blocks_q[idx_q] + 2'd1;
`else
    assign blk_d = BLOCK_DESTROYED;
`endif
    assign dcnt_d  = dcnt_q + 5'(blk_d == BLOCK_DESTROYED);
    assign score_d = score_q + 16'(score_q != 16'hFFFF);

    always_ff @(posedge CLK_50MH or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            ball_x_q   <= '0;
            ball_y_q   <= '0;
            blocks_q   <= '0;
            dcnt_q     <= '0;
            score_q    <= '0;
            pos_q      <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b1;
            centre_q   <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            busy_q     <= state_q != IDLE;
            if (clear_req) begin
                state_q <= CLEAR;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    CLEAR: begin
                        we_q            <= 1'b1;
                        pos_q           <= 6'(idx_q);
                        data_q          <= '0;
                        blocks_q[idx_q] <= '0;
                        score_q         <= '0;
                        dcnt_q          <= '0;
                        level_q         <= 1'b0;
                        idx_q           <= last_idx ? '0 : idx_q + 5'd1;
                        state_q         <= last_idx ? IDLE : CLEAR;
                    end
                    IDLE: if (frame_tick) begin
                        ball_x_q <= ball_x;
                        ball_y_q <= ball_y;
                        idx_q    <= '0;
                        state_q  <= SCAN;
                    end
                    SCAN: begin
                        centre_q <= centre_in_x;
                        state_q  <= hit ? WRITE : (last_idx ? IDLE : SCAN);
                        idx_q    <= (hit || last_idx) ? idx_q : idx_q + 5'd1;
                    end
                    WRITE: begin
                        we_q            <= 1'b1;
                        pos_q           <= 6'(idx_q);
                        data_q          <= blk_d;
                        blocks_q[idx_q] <= blk_d;
                        bounce_y_q      <= centre_q;
                        bounce_x_q      <= !centre_q;
                        score_q         <= score_d;
                        dcnt_q          <= dcnt_d;
                        level_q         <= dcnt_d == 5'(NUM_BLOCKS);
                        state_q         <= IDLE;
                    end
                    default: state_q <= CLEAR;
                endcase
            end
        end
    end

    assign active_write_enable = we_q;
    assign active_position     = pos_q;
    assign active_data         = data_q;
    assign bounce_x            = bounce_x_q;
    assign bounce_y            = bounce_y_q;
    assign score               = score_q;
    assign level_clear         = level_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_block_hit_engine.sv
// tb_block_hit_engine: scoreboard bench; expected writes queued at stimulus, popped on each strobe
module tb_block_hit_engine;
    logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, clear_req = 1'b0;
    logic [9:0]  ball_x = '0, ball_y = '0;
    logic        we, bounce_x, bounce_y, level_clear, busy;
    logic [5:0]  pos;
    logic [1:0]  data;
    logic [15:0] score;
    int cyc = 0, n_tests = 0, n_fail = 0;
    typedef struct {int cyc; int pos; int data; int bx; int by;} wr_t;
    wr_t sb[$];
    wr_t mon_e;
    int mstate[25];
    int mscore = 0, mdcnt = 0;
`ifdef BLOCK_HITS_MULTI_EN
    localparam int HITS = 3;
`else
    localparam int HITS = 1;
`endif

    block_hit_engine dut (
        .CLK_50MH(clk), .reset_n(rst_n), .frame_tick(frame_tick), .clear_req(clear_req),
        .ball_x(ball_x), .ball_y(ball_y), .active_write_enable(we), .active_position(pos),
        .active_data(data), .bounce_x(bounce_x), .bounce_y(bounce_y), .score(score),
        .level_clear(level_clear), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (we) begin
            check("write_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("wr_cycle", cyc, mon_e.cyc);
                check("wr_pos", int'(pos), mon_e.pos);
                check("wr_data", int'(data), mon_e.data);
                check("wr_bounce_x", int'(bounce_x), mon_e.bx);
                check("wr_bounce_y", int'(bounce_y), mon_e.by);
            end
        end else begin
            check("bounce_idle", int'({bounce_x, bounce_y}), 0);
        end
    end

    task automatic push_clear(input int base);
        wr_t e;
        for (int j = 0; j < 25; j++) begin
            e = '{base + j, j, 0, 0, 0};
            sb.push_back(e);
            mstate[j] = 0;
        end
        mscore = 0;
        mdcnt  = 0;
    endtask

    function automatic int find_hit(input int x, input int y, output int cin);
        int bx, by;
        cin = 0;
        for (int k = 0; k < 25; k++) begin
            bx = 40 + 120 * (k % 5);
            by = 40 + 50 * (k / 5);
            if (mstate[k] != 3 && x <= bx + 80 && x + 7 >= bx && y <= by + 30 && y + 7 >= by) begin
                cin = (x + 3 >= bx && x + 3 <= bx + 80) ? 1 : 0;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic settle(input int lb);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (cyc == lb) check("busy_high", int'(busy), 1);
            if (cyc == lb + 1) check("busy_low", int'(busy), 0);
        end
    endtask

    task automatic frame(input int x, input int y);
        int t, k, cin, nd;
        wr_t e;
        @(negedge clk);
        ball_x = 10'(x);
        ball_y = 10'(y);
        frame_tick = 1'b1;
        t = cyc + 1;
        k = find_hit(x, y, cin);
        if (k >= 0) begin
            nd = (HITS == 3) ? mstate[k] + 1 : 3;
            e = '{t + 2 + k, k, nd, 1 - cin, cin};
            sb.push_back(e);
            mstate[k] = nd;
            if (mscore < 65535) mscore++;
            if (nd == 3) mdcnt++;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        settle(k >= 0 ? t + 2 + k : t + 25);
        check("score", int'(score), mscore);
        check("level_clear", int'(level_clear), int'(mdcnt == 25));
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_data", int'(data), 0);
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level_clear), 0);
        check("rst_busy", int'(busy), 1);
        rst_n = 1'b1;
        t = cyc + 1;
        push_clear(t);
        settle(t + 24);
        check("score_after_clear", int'(score), 0);
        frame(60, 50);
        frame(118, 100);
        frame(300, 400);
        repeat (3) frame(60, 50);
        // clear and tick together: clear wins
        @(negedge clk);
        ball_x = 10'd60; ball_y = 10'd50;
        frame_tick = 1'b1; clear_req = 1'b1;
        t = cyc + 1;
        push_clear(t + 1);
        @(negedge clk);
        frame_tick = 1'b0; clear_req = 1'b0;
        settle(t + 25);
        check("score_clear_tick", int'(score), 0);
        frame(60, 50);
        // abort a scan while block 10 is under test; block 12 would otherwise be hit
        @(negedge clk);
        ball_x = 10'd300; ball_y = 10'd150; frame_tick = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (10) @(negedge clk);
        clear_req = 1'b1;
        push_clear(t + 12);
        @(negedge clk);
        clear_req = 1'b0;
        settle(t + 36);
        check("score_abort", int'(score), 0);
        for (int i = 0; i < 25; i++)
            repeat (HITS) frame(40 + 120 * (i % 5) + 10, 40 + 50 * (i / 5) + 10);
        check("level_set", int'(level_clear), 1);
        @(negedge clk);
        clear_req = 1'b1;
        t = cyc + 1;
        push_clear(t + 1);
        @(negedge clk);
        clear_req = 1'b0;
        settle(t + 25);
        check("level_cleared", int'(level_clear), 0);
        check("score_cleared", int'(score), 0);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/block_hit_engine.md
# block_hit_engine

Writer side of the block-state interface consumed by the VGA renderer. Once per frame it latches the ball position and scans the 25-block wall, one block per cycle, for ball/block overlap. On the first hit it advances that block's damage state and issues one write (`active_write_enable` / `active_position` / `active_data`). It also reports bounce direction, score and level-clear status to the game controller. After reset or `clear_req` it restores every block to intact by writing 0 to all 25 positions.

## Interface
Parameters:
- `BALL_SIZE`, 7: ball box spans `ball_x..ball_x+BALL_SIZE`, inclusive.
- `BLOCK_SPACING_X`, 40: left margin and horizontal gap between blocks.
- `BLOCK_WIDTH`, 80: block x span `bx..bx+BLOCK_WIDTH`, inclusive.
- `BLOCK_HEIGHT`, 30: block y span `by..by+BLOCK_HEIGHT`, inclusive.
- `FIRST_ROW_Y`, 40: y of row 0.
- `ROW_PITCH`, 50: y step between rows.

Ports (one clock, `CLK_50MH`; reset is asynchronous and active-low):
- `CLK_50MH`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `frame_tick`  in  1: one-cycle pulse per frame (vblank start).
- `clear_req`  in  1: synchronous request to restore all blocks and zero score.
- `ball_x`  in  10: ball left edge.
- `ball_y`  in  10: ball top edge.
- `active_write_enable`  out  1: one-cycle write strobe.
- `active_position`  out  6: block index 0..24.
- `active_data`  out  2: new block state; 3 means destroyed.
- `bounce_x`  out  1: one-cycle pulse, side hit.
- `bounce_y`  out  1: one-cycle pulse, top/bottom hit.
- `score`  out  16: hit count, saturating.
- `level_clear`  out  1: all 25 blocks destroyed.
- `busy`  out  1: high in CLEAR, SCAN and WRITE.

## Operation
- Block index `i` maps to `row = i/5` and `col = i%5`.
  - `bx = BLOCK_SPACING_X + (BLOCK_SPACING_X+BLOCK_WIDTH)*col`
  - `by = FIRST_ROW_Y + ROW_PITCH*row`
- Internal 25×2-bit state array mirrors the renderer's array. A destroyed-count register runs 0..25.
- FSM states:
  - CLEAR: index 0..24, one write per cycle with data 0; zeroes the state array, score and destroyed count. Goes to IDLE after index 24.
  - IDLE: waits for `frame_tick`. On `frame_tick`, latches `ball_x`/`ball_y`, sets index to 0 and goes to SCAN.
  - SCAN: tests block `index`.
    - Hit (state != 3 and overlap): capture the index and go to WRITE.
    - Otherwise at index 24, go to IDLE; else index+1.
  - WRITE: registered outputs assert for exactly one cycle, then IDLE. At most one hit per frame.
- Overlap test: `ball_x <= bx+BLOCK_WIDTH`, `ball_x+BALL_SIZE >= bx`, `ball_y <= by+BLOCK_HEIGHT`, `ball_y+BALL_SIZE >= by`. All sums are 11-bit, with no wrap.
- Bounce direction:
  - `bounce_y` if the ball centre `ball_x+3` lies in `[bx, bx+BLOCK_WIDTH]`.
  - Otherwise `bounce_x`.
  - Exactly one pulses, in the WRITE cycle.
- On a hit:
  - `score` increments and saturates at `0xFFFF`.
  - If the new state is 3, destroyed count increments.
  - `level_clear` is high when destroyed count == 25, until CLEAR.
- `frame_tick` is ignored outside IDLE.
- `clear_req` in any state, including mid-SCAN or WRITE, aborts and enters CLEAR at index 0 on the next cycle. If `clear_req` and `frame_tick` arrive together, clear wins.

## Timing
- Reset values:
  - `active_write_enable`, `active_position`, `active_data`, `bounce_x`, `bounce_y`: 0.
  - `score`: 0. `level_clear`: 0.
  - State is CLEAR index 0, so `busy` = 1.
  - Assertion of `reset_n` mid-operation takes effect immediately.
- CLEAR writes occur at cycles 1..25 after reset release (position = cycle−1), then IDLE; `busy` drops at cycle 26.
- `frame_tick` sampled at cycle t: block k is tested at cycle t+1+k. A hit on k gives the write strobe at cycle t+2+k.
- Worst-case scan is 25 cycles, far below frame time.
- All outputs are registered. `score` and `level_clear` update in the WRITE cycle.

## Configuration
- `BLOCK_HITS_MULTI_EN` defined: a hit advances state 0→1→2→3, so a block takes three hits. The renderer's colour shifts with each hit.
- Not defined: a hit writes 3 directly, so a block takes one hit.

## Structure
- Package `breakout_pkg` holds:
  - `NUM_BLOCKS` = 25 and `BLOCKS_PER_ROW` = 5.
  - `BLOCK_DESTROYED` = 2'b11.
  - Layout constant defaults, shared with the renderer.
  - FSM state enum (CLEAR, IDLE, SCAN, WRITE).
- Sub-module `block_overlap_check` (combinational): takes the index and latched ball position; outputs `hit_box` and `centre_in_x`.

## Test plan
- Reset release: 25 strobes, positions 0..24, data 0, on consecutive cycles; then `busy` = 0 and `score` = 0.
- Ball at (60,50) with `frame_tick`:
  - Write to position 0 two cycles after the tick, with `bounce_y`.
  - Data is 1 with the macro, 3 without. `score` = 1.
- Ball at (118,100):
  - Block 5 hit; centre 121 > 120, so `bounce_x`.
  - Strobe 7 cycles after the tick.
- Ball at (300,400): no strobe within 25 cycles; `busy` drops after 25 cycles.
- With the macro, four frames at (60,50):
  - Data 1, 2, 3, then no fourth write.
  - `score` = 3 and block 0 counted destroyed.
- `clear_req` during SCAN at index 10: scan aborts, no hit write, 25 clear writes follow, `score` → 0. Destroying all 25 blocks sets `level_clear` = 1, and `clear_req` returns it to 0.
